// File: rtl/imm_field_encoder.sv
// imm_field_encoder
//   Scatters a 32-bit immediate into the immediate fields of a RISC-V
//   instruction template (the inverse of the decode immediate generator).
//   It range-checks the immediate and registers the result behind a
//   valid/ready output stage.
//
//   Optional feature (macro IMM_ENC_SPLIT_EN): an out-of-range I-type
//   constant with in_split=1 is expanded into two beats, LUI rd,hi
//   followed by the original I-type op with rs1=rd and the low 12 bits.
//   When the macro is undefined, in_split is ignored and the HI state does
//   not exist.
//
// Ports
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     request handshake
//   in_type               0=R 1=I 2=S 3=B 4=U 5=J (6/7 illegal)
//   in_inst               template; bits outside the immediate fields are copied
//   in_imm                immediate, two's complement
//   in_split              permit LUI+I expansion (I-type only)
//   out_valid/out_ready   beat handshake
//   out_inst              encoded instruction
//   out_err               immediate not representable (truncated encoding sent)
//   out_last              final beat of the request
module imm_field_encoder #(
  parameter logic [6:0] OPC_LUI = 7'b0110111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_imm,
  input  logic        in_split,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

`ifdef IMM_ENC_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1, HI = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, ONE = 1'b1} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] enc;
  logic        rng_err;
  logic        accept;
  logic        split_req;
  state_t      load_st;

  // ---------------- field scatter + range check ----------------
  always_comb begin
    enc     = in_inst;
    rng_err = 1'b0;
    case (in_type)
      RTYPE: ;
      ITYPE: begin
        enc[31:20] = in_imm[11:0];
        rng_err    = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      STYPE: begin
        enc[31:25] = in_imm[11:5];
        enc[11:7]  = in_imm[4:0];
        rng_err    = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      BTYPE: begin
        enc[31]    = in_imm[12];
        enc[30:25] = in_imm[10:5];
        enc[11:8]  = in_imm[4:1];
        enc[7]     = in_imm[11];
        rng_err    = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
      end
      UTYPE: begin
        enc[31:12] = in_imm[31:12];
        rng_err    = |in_imm[11:0];
      end
      JTYPE: begin
        enc[31]    = in_imm[20];
        enc[30:21] = in_imm[10:1];
        enc[20]    = in_imm[11];
        enc[19:12] = in_imm[19:12];
        rng_err    = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
      end
      default: rng_err = 1'b1;
    endcase
  end

`ifdef IMM_ENC_SPLIT_EN
  // LUI upper part is rounded so the sign-extended low 12 bits add back
  // correctly: (imm + 0x800) >> 12, where the carry into bit 12 is imm[11].
  logic [19:0] hi20;
  logic [31:0] lui_beat, lo_beat, lo_q;
  assign hi20      = in_imm[31:12] + {19'd0, in_imm[11]};
  assign lui_beat  = {hi20, in_inst[11:7], OPC_LUI};
  assign lo_beat   = {in_imm[11:0], in_inst[11:7], in_inst[14:0]};
  assign split_req = (in_type == ITYPE) && in_split && rng_err;
  assign load_st   = split_req ? HI : ONE;
`else
  logic unused_split;
  assign unused_split = in_split;
  assign split_req    = 1'b0;
  assign load_st      = ONE;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = load_st;
      ONE:  if (out_ready) state_nxt = accept ? load_st : IDLE;
`ifdef IMM_ENC_SPLIT_EN
      HI:   if (out_ready) state_nxt = ONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    out_valid = (state != IDLE);
`ifdef IMM_ENC_SPLIT_EN
    in_ready  = (state == IDLE) || ((state == ONE) && out_ready);
`else
    in_ready  = !out_valid || out_ready;
`endif
  end

  assign accept = in_valid && in_ready;

  // ---------------- output beat register ----------------
  // Only loads on accept or on the HI->ONE hand-over, so the beat is held
  // steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_inst <= '0;
      out_err  <= 1'b0;
      out_last <= 1'b0;
`ifdef IMM_ENC_SPLIT_EN
      lo_q     <= '0;
`endif
    end else if (accept) begin
`ifdef IMM_ENC_SPLIT_EN
      out_inst <= split_req ? lui_beat : enc;
      lo_q     <= lo_beat;
`else
      out_inst <= enc;
`endif
      out_err  <= rng_err && !split_req;
      out_last <= !split_req;
`ifdef IMM_ENC_SPLIT_EN
    end else if ((state == HI) && out_ready) begin
      out_inst <= lo_q;
      out_err  <= 1'b0;
      out_last <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// tb_imm_field_encoder
//   Directed bench for imm_field_encoder. A queue-based model predicts every
//   output beat from the encoding rules using integer arithmetic; a single
//   negedge monitor compares handshake, beats and hold stability each cycle,
//   and also evaluates hand-computed literal expectations posted by the
//   driver. Build with or without IMM_ENC_SPLIT_EN, matching the DUT.
module tb_imm_field_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_split;
  logic [2:0]  in_type;
  logic [31:0] in_inst, in_imm;
  logic        out_valid, out_ready, out_err, out_last;
  logic [31:0] out_inst;

  imm_field_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_inst(in_inst), .in_imm(in_imm), .in_split(in_split),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic        last;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;

  // literal expectation mailbox: written by driver, read by monitor
  int          lit_seq = 0;
  int          lit_seen = 0;
  string       lit_name;
  logic [31:0] lit_inst;
  logic        lit_err, lit_last, lit_vld, lit_rdy;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Model: what the encoder must emit for one accepted request.
  task automatic model(input logic [2:0] t, input logic [31:0] ins,
                       input logic [31:0] imm, input logic sp);
    int s;
    bit ok;
    logic [31:0] e;
    s  = $signed(imm);
    ok = 1'b1;
    e  = ins;
    case (t)
      3'd0: ;
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        e  = (ins & 32'h000FFFFF) | (imm << 20);
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        e  = (ins & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd3: begin
        ok = (imm[0] == 1'b0) && (s >= -4096) && (s <= 4095);
        e  = (ins & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) |
             (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 32'h1) << 7);
      end
      3'd4: begin
        ok = (imm & 32'hFFF) == 32'h0;
        e  = (ins & 32'hFFF) | (imm & 32'hFFFFF000);
      end
      3'd5: begin
        ok = (imm[0] == 1'b0) && (s >= -(1 << 20)) && (s <= (1 << 20) - 1);
        e  = (ins & 32'hFFF) | (((imm >> 20) & 32'h1) << 31) |
             (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
             (imm & 32'h000FF000);
      end
      default: ok = 1'b0;
    endcase
`ifdef IMM_ENC_SPLIT_EN
    if (t == 3'd1 && sp && !ok) begin
      logic [31:0] hi, rd;
      hi = (imm + 32'h800) & 32'hFFFFF000;
      rd = (ins >> 7) & 32'h1F;
      q.push_back('{hi | (rd << 7) | 32'h37, 1'b0, 1'b0});
      q.push_back('{(ins & 32'h00007FFF) | (rd << 15) | (imm << 20), 1'b0, 1'b1});
    end else
      q.push_back('{e, !ok, 1'b1});
`else
    if (sp) q.push_back('{e, !ok, 1'b1});
    else    q.push_back('{e, !ok, 1'b1});
`endif
  endtask

  // ---------------- monitor / compare ----------------
  logic        hold_v = 1'b0;
  logic [31:0] hold_inst;
  logic        hold_err, hold_last;

  always @(negedge clk) begin
    logic exp_rdy;
    beat_t h;
    if (lit_seq != lit_seen) begin
      chk({lit_name, ".inst"}, out_inst, lit_inst);
      chk({lit_name, ".err"}, 32'(out_err), 32'(lit_err));
      chk({lit_name, ".last"}, 32'(out_last), 32'(lit_last));
      chk({lit_name, ".valid"}, 32'(out_valid), 32'(lit_vld));
      chk({lit_name, ".in_ready"}, 32'(in_ready), 32'(lit_rdy));
      lit_seen = lit_seq;
    end
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
`ifdef IMM_ENC_SPLIT_EN
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
`else
      exp_rdy = (q.size() == 0) || out_ready;
`endif
      chk("m.out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m.in_ready", 32'(in_ready), 32'(exp_rdy));
      if (hold_v && out_valid) begin
        chk("m.hold_inst", out_inst, hold_inst);
        chk("m.hold_err", 32'(out_err), 32'(hold_err));
        chk("m.hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready && q.size() > 0) begin
        h = q.pop_front();
        chk("m.beat_inst", out_inst, h.inst);
        chk("m.beat_err", 32'(out_err), 32'(h.err));
        chk("m.beat_last", 32'(out_last), 32'(h.last));
      end
      hold_v    = out_valid && !out_ready;
      hold_inst = out_inst;
      hold_err  = out_err;
      hold_last = out_last;
      if (in_valid && in_ready) model(in_type, in_inst, in_imm, in_split);
    end
  end

  // ---------------- driver ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input logic [31:0] i, input logic e,
                     input logic l, input logic v, input logic r);
    lit_name = n; lit_inst = i; lit_err = e; lit_last = l; lit_vld = v; lit_rdy = r;
    lit_seq++;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_type  = 3'd1;
    in_inst  = 32'hFFFFFFFF;
    in_imm   = 32'hDEADBEEF;
    in_split = 1'b1;
  endtask

  // Returns at posedge+1 of the edge that accepted the request.
  task automatic send(input logic [2:0] t, input logic [31:0] ins,
                      input logic [31:0] imm, input logic sp);
    logic acc;
    int n;
    in_valid = 1'b1; in_type = t; in_inst = ins; in_imm = imm; in_split = sp;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
      if (!acc && n > 20) begin
        $display("FAIL send_timeout actual=in_ready_low expected=accept t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "accept timeout");
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (2) tick();
    lit("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    send(3'd1, 32'h00000293, 32'hFFFFFFFF, 1'b0); idle();
    lit("itype", 32'hFFF00293, 1'b0, 1'b1, 1'b1, 1'b1); tick(); tick();
    send(3'd2, 32'h00000023, 32'hFFFFFFFF, 1'b0); idle();
    lit("stype", 32'hFE000FA3, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    send(3'd3, 32'h00000063, 32'hFFFFFFFC, 1'b0); idle();
    lit("btype_neg", 32'hFE000EE3, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    send(3'd3, 32'h00000063, 32'h00000003, 1'b0); idle();
    lit("btype_odd", 32'h00000163, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    send(3'd5, 32'h0000006F, 32'h00000800, 1'b0); idle();
    lit("jtype", 32'h0010006F, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    send(3'd7, 32'h12345678, 32'h0, 1'b0); idle();
    lit("type7", 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1); tick(); tick();

    // split request held under backpressure, inputs scrambled after accept
    out_ready = 1'b0;
    send(3'd1, 32'h00000513, 32'h12345FFF, 1'b1); idle();
    for (int i = 0; i < 4; i++) begin
`ifdef IMM_ENC_SPLIT_EN
      lit("split_b1", 32'h12346537, 1'b0, 1'b0, 1'b1, 1'b0);
`else
      lit("nosplit", 32'hFFF00513, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
      tick();
    end
    out_ready = 1'b1;
    tick();
`ifdef IMM_ENC_SPLIT_EN
    lit("split_b2", 32'hFFF50513, 1'b0, 1'b1, 1'b1, 1'b1);
`else
    lit("nosplit_done", 32'hFFF00513, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
    tick(); tick();

    // back-to-back U-type, one beat per cycle
    for (int k = 1; k <= 4; k++) begin
      send(3'd4, 32'h00000037, 32'(k) << 12, 1'b0);
      lit("utype_b2b", 32'h00000037 | (32'(k) << 12), 1'b0, 1'b1, 1'b1, 1'b1);
    end
    idle(); tick(); tick();
    send(3'd4, 32'h00000037, 32'h00000001, 1'b0); idle();
    lit("utype_err", 32'h00000037, 1'b1, 1'b1, 1'b1, 1'b1); tick(); tick();

    // reset while the first split beat is held
    out_ready = 1'b0;
    send(3'd1, 32'h00000513, 32'h12345FFF, 1'b1); idle();
    #2 rst = 1'b1;
    #1 lit("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("post_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick();

    send(3'd0, 32'h00B50533, 32'h55AA55AA, 1'b0); idle();
    lit("rtype", 32'h00B50533, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
